// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one shared uart_tx to N_REQ byte-stream requesters a whole packet at a time; define UART_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    uart_start,
  output logic [DATA_W-1:0]       uart_data,
  input  logic                    uart_ready
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;
  state_t state;
  logic [IW-1:0] owner, win, sel;
  logic last_q, load;
`ifdef UART_ARB_FIXED_PRIO_EN
  // lowest-index requester wins; high indices may starve
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] ptr, nxt;
  assign nxt = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
  // first requester at or after the pointer, wrapping past N_REQ-1
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) win = IW'((int'(ptr) + i) % N_REQ);
  end
`endif
  assign sel  = (state == HOLD) ? owner : win;
  assign load = (state == IDLE && |req) || (state == HOLD && req[owner]);
  assign busy = |gnt;
  // packet FSM: grant, then per byte latch+ack, start, wait for the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_q     <= 1'b0;
      gnt        <= '0;
      ack        <= '0;
      uart_start <= 1'b0;
      uart_data  <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      ack <= '0;
      if (load) begin
        owner      <= sel;
        gnt        <= N_REQ'(1) << sel;
        ack        <= N_REQ'(1) << sel;
        uart_data  <= data[DATA_W*int'(sel) +: DATA_W];
        last_q     <= last[sel];
        uart_start <= 1'b1;
        state      <= SEND;
      end else begin
        case (state)
          SEND: if (!uart_ready) begin
            uart_start <= 1'b0;
            state      <= WAIT;
          end
          WAIT: if (uart_ready) state <= last_q ? IDLE : HOLD;
          default: ;
        endcase
        if ((state == WAIT && uart_ready && last_q) || state == HOLD) begin
          gnt   <= '0;
          state <= IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr   <= nxt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed corner cases plus randomized packet traffic against a packet-level model
module tb_uart_tx_arbiter;
  localparam int N = 4, NP = 3, ML = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, last = '0, ack, gnt;
  logic [N*8-1:0] data = '0;
  logic busy, uart_start, uart_ready = 1'b1;
  logic [7:0] uart_data;
  int checks = 0, errors = 0;
  logic [7:0] mem [N][NP][ML];
  int len [N][NP];
  int snd [N][NP];
  int pk [N];
  int bi [N];
  bit done [N];
  int exp_q [$];
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last), .ack(ack), .gnt(gnt),
    .busy(busy), .uart_start(uart_start), .uart_data(uart_data), .uart_ready(uart_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, uart_start, 0);
    check({tag, "_data"}, uart_data, 0);
  endtask
  function automatic void gen_packets();
    for (int i = 0; i < N; i++) begin
      pk[i] = 0;
      bi[i] = 0;
      done[i] = 0;
      for (int p = 0; p < NP; p++) begin
        len[i][p] = $urandom_range(1, ML);
        for (int b = 0; b < ML; b++) mem[i][p][b] = 8'($urandom);
        snd[i][p] = len[i][p];
        if (p == NP - 1 && len[i][p] > 1 && $urandom_range(0, 1) == 1)
          snd[i][p] = $urandom_range(1, len[i][p] - 1);
      end
    end
  endfunction
  function automatic void build_model();
    int mp [N];
    int ptr, w;
    ptr = 0;
    for (int i = 0; i < N; i++) mp[i] = 0;
    for (int k = 0; k < N * NP; k++) begin
      w = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int j = N - 1; j >= 0; j--) if (mp[j] < NP) w = j;
`else
      for (int j = N - 1; j >= 0; j--) if (mp[(ptr + j) % N] < NP) w = (ptr + j) % N;
`endif
      for (int b = 0; b < snd[w][mp[w]]; b++) exp_q.push_back(w * 256 + int'(mem[w][mp[w]][b]));
      mp[w]++;
      ptr = (w + 1) % N;
    end
  endfunction
  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        req[i] = 1'b0;
        last[i] = 1'b0;
        data[i*8 +: 8] = 8'h00;
      end else begin
        req[i] = 1'b1;
        last[i] = (bi[i] == len[i][pk[i]] - 1);
        data[i*8 +: 8] = mem[i][pk[i]][bi[i]];
      end
    end
  endtask
  task automatic take_acks();
    for (int i = 0; i < N; i++) begin
      if (ack[i] && !done[i]) begin
        if (bi[i] + 1 == snd[i][pk[i]] && snd[i][pk[i]] < len[i][pk[i]]) done[i] = 1;
        else if (bi[i] == len[i][pk[i]] - 1) begin
          bi[i] = 0;
          pk[i]++;
          if (pk[i] == NP) done[i] = 1;
        end else bi[i]++;
      end
    end
  endtask
  initial begin
    int cyc, dly, bsy, got_o, exp;
    bit pend, cap, all_done;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    req[2] = 1'b1;
    data[2*8 +: 8] = 8'h41;
    last[2] = 1'b1;
    @(negedge clk);
    check("sb_gnt", gnt, 4'b0100);
    check("sb_ack", ack, 4'b0100);
    check("sb_start", uart_start, 1);
    check("sb_data", uart_data, 8'h41);
    check("sb_busy", busy, 1);
    req[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("slow_start", uart_start, 1);
      check("slow_ack", ack, 0);
    end
    uart_ready = 1'b0;
    @(negedge clk);
    check("slow_drop", uart_start, 0);
    check("slow_gnt", gnt, 4'b0100);
    repeat (2) begin
      @(negedge clk);
      check("slow_one_start", uart_start, 0);
    end
    uart_ready = 1'b1;
    @(negedge clk);
    check("sb_release", gnt, 0);
    check("sb_busy_lo", busy, 0);
    req[3] = 1'b1;
    data[3*8 +: 8] = 8'h11;
    last[3] = 1'b0;
    @(negedge clk);
    check("ab_gnt", gnt, 4'b1000);
    check("ab_ack", ack, 4'b1000);
    check("ab_data", uart_data, 8'h11);
    req[3] = 1'b0;
    uart_ready = 1'b0;
    @(negedge clk);
    check("ab_wait_start", uart_start, 0);
    uart_ready = 1'b1;
    @(negedge clk);
    check("ab_hold_gnt", gnt, 4'b1000);
    check("ab_hold_ack", ack, 0);
    @(negedge clk);
    check("ab_gnt_clr", gnt, 0);
    check("ab_no_start", uart_start, 0);
    req[1] = 1'b1;
    data[1*8 +: 8] = 8'h5A;
    last[1] = 1'b1;
    req[3] = 1'b1;
    data[3*8 +: 8] = 8'h33;
    last[3] = 1'b1;
    @(negedge clk);
    check("ptr_wrap_gnt", gnt, 4'b0010);
    check("ptr_wrap_data", uart_data, 8'h5A);
    req[3] = 1'b0;
    uart_ready = 1'b0;
    @(negedge clk);
    check("mid_wait", uart_start, 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    uart_ready = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", gnt, 4'b0010);
    check("post_rst_ack", ack, 4'b0010);
    check("post_rst_start", uart_start, 1);
    check("post_rst_data", uart_data, 8'h5A);
    req[1] = 1'b0;
    uart_ready = 1'b0;
    @(negedge clk);
    uart_ready = 1'b1;
    @(negedge clk);
    check("post_rst_release", gnt, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gen_packets();
    build_model();
    present();
    pend = 0;
    dly = $urandom_range(0, 3);
    bsy = 0;
    cyc = 0;
    while ((exp_q.size() > 0 || gnt != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      check("gnt_onehot", $onehot0(gnt), 1);
      check("busy_match", busy, |gnt);
      check("ack_owner", ack & ~gnt, 0);
      if (pend) check("start_held", uart_start, 1);
      cap = 0;
      if (!uart_ready) begin
        bsy--;
        if (bsy == 0) begin
          uart_ready = 1'b1;
          dly = $urandom_range(0, 3);
        end
      end else if (uart_start) begin
        if (dly == 0) begin
          got_o = -1;
          for (int i = 0; i < N; i++) if (gnt[i]) got_o = i;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          check("tx_byte", got_o * 256 + int'(uart_data), exp);
          uart_ready = 1'b0;
          bsy = $urandom_range(1, 4);
          cap = 1;
        end else dly--;
      end
      pend = uart_start && !cap;
      take_acks();
      present();
    end
    check("timeout", cyc < 20000, 1);
    repeat (4) @(negedge clk);
    all_done = 1;
    for (int i = 0; i < N; i++) all_done &= done[i];
    check("end_all_done", all_done, 1);
    check("end_left", exp_q.size(), 0);
    check("end_gnt", gnt, 0);
    check("end_start", uart_start, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `N_REQ` byte-stream requesters, such as keypad echo, lock-status messages and debug traces, in the smart-lock design. Each requester presents bytes with a `last` flag. The arbiter grants the transmitter for a whole packet and sequences the UART's `start`/`ready` handshake byte by byte. Round-robin arbitration is the default; fixed priority is available as a compile option.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width; fixed to 8 by the UART.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request; `data`/`last` are valid while high.
- `data`  in  N_REQ*8  packed bytes; requester i uses `[8i+7:8i]`.
- `last`  in  N_REQ  per-requester flag: this byte ends the packet.
- `ack`  out  N_REQ  one-cycle pulse: byte of requester i consumed.
- `gnt`  out  N_REQ  one-hot owner of the transmitter; 0 when idle.
- `busy`  out  1  high whenever `gnt` is non-zero.
- `uart_start`  out  1  to UART `start`.
- `uart_data`  out  8  to UART `data_tx`.
- `uart_ready`  in  1  from UART `ready`: high means idle, low means shifting.

## Operation
FSM states are IDLE, SEND, WAIT and HOLD. `owner` is the granted index. `byte_q`/`last_q` are the latched byte and its last flag.
- **IDLE.** `gnt`=0, `uart_start`=0.
  - If any `req` is high: choose a winner, latch `data[w]`→`byte_q` and `last[w]`→`last_q`, set `gnt[w]`, pulse `ack[w]`, go to SEND.
- **SEND.** `uart_start`=1, `uart_data`=`byte_q`.
  - When `uart_ready`=0 (UART accepted), go to WAIT.
- **WAIT.** `uart_start`=0.
  - When `uart_ready`=1 (stop bit done):
    - `last_q`=1: clear `gnt`, advance the RR pointer to `owner+1` (mod `N_REQ`), go to IDLE.
    - Otherwise go to HOLD.
- **HOLD.** `gnt` is kept.
  - `req[owner]`=1: latch the next byte and last flag, pulse `ack[owner]`, go to SEND.
  - `req[owner]`=0: abort the packet, clear `gnt`, advance the pointer, go to IDLE.
- **Round-robin.** Search starts at the pointer and wraps at `N_REQ-1`→0. The pointer resets to 0.
- **Requester rule.** After seeing `ack`, present the next byte or drop `req` by the following edge. Holding `req` with an unchanged byte sends it again.
- **`ack`.** Never asserted in SEND or WAIT. At most one bit is high.
- **Non-owner requests.** Ignored while `gnt`≠0, but stay pending. A non-owner cannot preempt a packet.
- **Reset.** Takes effect mid-operation on the next edge: state → IDLE. `gnt`, `ack`, `busy`, `uart_start` → 0; `uart_data` → 0x00; pointer → 0. The UART shares `rst` through its inverted `rstn`.

## Timing
- `req` high in IDLE at edge k: `gnt`/`ack`/`uart_start` are high in cycle k+1 with `uart_data` valid. Latency is 1 cycle.
- `uart_start` stays high until `uart_ready` is seen low, then drops on the next edge. No lost starts if the UART is slow to accept.
- Last byte: after `uart_ready` returns high, `gnt` drops 1 cycle later. A new grant is possible on the following edge, giving 1 IDLE cycle minimum between packets.
- Continuation byte in HOLD: `ack` plus `uart_start` follow 1 cycle after HOLD is entered when `req[owner]` is already high.
- All outputs are registered or decoded from state/registers only. There are no combinational paths from `req` to outputs.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: winner is the lowest-index `req`; the pointer register is removed. Starvation of high indices is accepted.
- Not defined: round-robin as described under Operation.

## Test plan
- **Single byte.** `req[2]`=1, `data`=0x41, `last`=1. Expect `ack[2]` for 1 cycle, `gnt`=4'b0100, UART receives 0x41, then `gnt`=0 and `req` dropped.
- **3-byte packet.** Requester 0 sends 0x4F,0x4B,0x0D; requester 1 is requesting throughout. Expect 0x4F 0x4B 0x0D on `tx` uninterrupted, then requester 1 is granted.
- **Round-robin fairness.** All 4 `req` high with single-byte packets, held for 8 packets. Grant order must be 0,1,2,3,0,1,2,3. With `UART_ARB_FIXED_PRIO_EN`, every grant goes to 0.
- **Abort.** Requester 3 sends 0x11 with `last`=0, then drops `req` before HOLD. Expect `gnt` to clear, no second `uart_start`, and the pointer to move to 0.
- **Slow accept.** Hold `uart_ready`=1 for 5 cycles after `uart_start` rises. `uart_start` must stay high for all 5 cycles, and only one byte may be transmitted.
- **Reset mid-byte.** Assert `rst` while in WAIT. On the next cycle all outputs are 0, `uart_data`=0x00, and a subsequent request from requester 1 is granted normally.
